// File: rtl/legv8_pkg.sv
// Shared LEGv8 core types: arbiter FSM states, requester IDs, defaults.
package legv8_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/arb_pick.sv
// 2-way fetch/data picker. ARB_ROUND_ROBIN_EN selects round-robin on
// conflict; otherwise data has fixed priority.
module arb_pick
    import legv8_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       last_id,
    output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt = '0;
        if (if_req && d_req) begin
            // favour whoever did not win last time
            if (last_id == REQ_I) gnt[REQ_D] = 1'b1;
            else                  gnt[REQ_I] = 1'b1;
        end else begin
            gnt[REQ_I] = if_req;
            gnt[REQ_D] = d_req;
        end
    end
`else
    logic unused_last_id;
    assign unused_last_id = last_id;

    always_comb begin
        gnt = '0;
        gnt[REQ_D] = d_req;
        gnt[REQ_I] = if_req & ~d_req;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported I/D memory between fetch and LDUR/STUR,
// one transaction at a time, waiting out the fixed read latency.
module mem_port_arbiter
    import legv8_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              id_q, id_d;
    logic              a2_q, a2_d;
    logic              last_q, last_d;
    logic              if_rv_q, if_rv_d;
    logic              d_rv_q, d_rv_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic [1:0]        pick;
    logic              if_gnt, d_gnt;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    arb_pick u_pick (
        .if_req  (bus.if_req),
        .d_req   (bus.d_req),
        .last_id (last_q),
        .gnt     (pick)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        a2_d       = a2_q;
        last_d     = last_q;
        if_rv_d    = 1'b0;
        d_rv_d     = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (!Reset && pick[REQ_D]) begin
                    d_gnt    = 1'b1;
                    mem_addr = bus.d_addr;
                    last_d   = REQ_D;
                    // stores finish at grant; only loads wait
                    if (bus.d_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = bus.d_wdata;
                    end else begin
                        mem_re  = 1'b1;
                        id_d    = REQ_D;
                        state_d = WAIT;
                        cnt_d   = 4'd1;
                    end
                end else if (!Reset && pick[REQ_I]) begin
                    if_gnt   = 1'b1;
                    mem_addr = bus.if_addr;
                    mem_re   = 1'b1;
                    last_d   = REQ_I;
                    id_d     = REQ_I;
                    a2_d     = bus.if_addr[2];
                    state_d  = WAIT;
                    cnt_d    = 4'd1;
                end
            end
            WAIT: begin
                if (cnt_q == LAT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (id_q == REQ_I) begin
                        if_rv_d    = 1'b1;
                        if_rdata_d = a2_q ? bus.mem_rdata[32 +: 32]
                                          : bus.mem_rdata[31:0];
                    end else begin
                        d_rv_d    = 1'b1;
                        d_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            id_q       <= REQ_I;
            a2_q       <= 1'b0;
            last_q     <= REQ_I;
            if_rv_q    <= 1'b0;
            d_rv_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            a2_q       <= a2_d;
            last_q     <= last_d;
            if_rv_q    <= if_rv_d;
            d_rv_q     <= d_rv_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_rvalid = if_rv_q;
    assign bus.d_rvalid  = d_rv_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q == WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on MEM_LAT 1/2/3 plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    logic rst3 = 1'b1;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b2 ();
    mem_port_arbiter_if b3 ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u1 (
        .CLK(CLK), .Reset(rst1), .bus(b1));
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) u2 (
        .CLK(CLK), .Reset(rst2), .bus(b2));
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u3 (
        .CLK(CLK), .Reset(rst3), .bus(b3));

    logic [63:0] mem_arr [logic [60:0]];
    logic [63:0] ref_mem [logic [60:0]];

    function automatic logic [63:0] init_word(logic [60:0] i);
        return {i[31:0] ^ 32'hC3A5_5A3C, i[31:0] * 32'h9E37_79B9};
    endfunction

    task automatic zero_inputs();
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0;
        b1.d_addr = 0; b1.d_wdata = 0; b1.mem_rdata = 0;
        b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0;
        b2.d_addr = 0; b2.d_wdata = 0; b2.mem_rdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0;
        b3.d_addr = 0; b3.d_wdata = 0; b3.mem_rdata = 0;
    endtask

    task automatic test_reset();
        b2.if_req = 1; b2.if_addr = 64'h40; b2.d_req = 1;
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        total++; if (b2.if_gnt !== 1'b0) begin bad++;
            $display("FAIL rst_hold_if_gnt got=%0h exp=0", b2.if_gnt); end
        total++; if (b2.d_gnt !== 1'b0) begin bad++;
            $display("FAIL rst_hold_d_gnt got=%0h exp=0", b2.d_gnt); end
        total++; if (b2.mem_re !== 1'b0) begin bad++;
            $display("FAIL rst_hold_mem_re got=%0h exp=0", b2.mem_re); end
        @(posedge CLK); #1;
        rst1 = 0; rst2 = 0; rst3 = 0;
        b2.if_req = 0; b2.d_req = 0;
        @(negedge CLK);
        total++; if (b2.busy !== 1'b0) begin bad++;
            $display("FAIL rst_busy got=%0h exp=0", b2.busy); end
        total++; if (b2.if_rvalid !== 1'b0) begin bad++;
            $display("FAIL rst_if_rvalid got=%0h exp=0", b2.if_rvalid); end
        total++; if (b2.d_rvalid !== 1'b0) begin bad++;
            $display("FAIL rst_d_rvalid got=%0h exp=0", b2.d_rvalid); end
        total++; if (b2.if_rdata !== 32'h0) begin bad++;
            $display("FAIL rst_if_rdata got=%0h exp=0", b2.if_rdata); end
        total++; if (b2.d_rdata !== 64'h0) begin bad++;
            $display("FAIL rst_d_rdata got=%0h exp=0", b2.d_rdata); end
        total++; if ({b2.if_gnt, b2.d_gnt, b2.mem_re, b2.mem_we} !== 4'h0)
        begin bad++;
            $display("FAIL rst_strobes got=%0h exp=0",
                     {b2.if_gnt, b2.d_gnt, b2.mem_re, b2.mem_we}); end
        total++; if (b2.mem_addr !== 64'h0) begin bad++;
            $display("FAIL rst_mem_addr got=%0h exp=0", b2.mem_addr); end
        total++; if ({b1.busy, b3.busy} !== 2'b00) begin bad++;
            $display("FAIL rst_busy13 got=%0h exp=0", {b1.busy, b3.busy}); end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_w;
        b2.mem_rdata = 64'hAAAA_BBBB_1111_2222;
        for (int n = 0; n < 2; n++) begin
            @(posedge CLK); #1;
            b2.if_req  = 1;
            b2.if_addr = (n == 0) ? 64'h40 : 64'h44;
            exp_w = (n == 0) ? 32'h1111_2222 : 32'hAAAA_BBBB;
            for (int k = 0; k < 5; k++) begin
                @(negedge CLK);
                total++; if (b2.if_gnt !== (k == 0)) begin bad++;
                    $display("FAIL fetch%0d_gnt c%0d got=%0h exp=%0h",
                             n, k, b2.if_gnt, (k == 0)); end
                total++; if (b2.busy !== (k == 1 || k == 2)) begin bad++;
                    $display("FAIL fetch%0d_busy c%0d got=%0h exp=%0h",
                             n, k, b2.busy, (k == 1 || k == 2)); end
                total++; if (b2.if_rvalid !== (k == 3)) begin bad++;
                    $display("FAIL fetch%0d_rvalid c%0d got=%0h exp=%0h",
                             n, k, b2.if_rvalid, (k == 3)); end
                if (k == 0) begin
                    total++;
                    if (b2.mem_addr !== b2.if_addr || b2.mem_re !== 1'b1)
                    begin bad++;
                        $display("FAIL fetch%0d_port got=%0h/%0h exp=%0h/1",
                                 n, b2.mem_addr, b2.mem_re, b2.if_addr); end
                end
                if (k == 3) begin
                    total++; if (b2.if_rdata !== exp_w) begin bad++;
                        $display("FAIL fetch%0d_rdata got=%0h exp=%0h",
                                 n, b2.if_rdata, exp_w); end
                end
                @(posedge CLK); #1;
                b2.if_req = 0;
            end
        end
    endtask

    task automatic test_store();
        @(posedge CLK); #1;
        b2.d_req = 1; b2.d_we = 1; b2.d_addr = 64'h80; b2.d_wdata = 64'h5;
        @(negedge CLK);
        total++; if (b2.d_gnt !== 1'b1 || b2.mem_we !== 1'b1) begin bad++;
            $display("FAIL store_gnt_we got=%0h/%0h exp=1/1",
                     b2.d_gnt, b2.mem_we); end
        total++; if (b2.mem_addr !== 64'h80 || b2.mem_wdata !== 64'h5)
        begin bad++;
            $display("FAIL store_port got=%0h/%0h exp=80/5",
                     b2.mem_addr, b2.mem_wdata); end
        total++; if (b2.mem_re !== 1'b0) begin bad++;
            $display("FAIL store_re got=%0h exp=0", b2.mem_re); end
        @(posedge CLK); #1;
        b2.d_req = 0; b2.d_we = 0;
        b2.if_req = 1; b2.if_addr = 64'h48;
        @(negedge CLK);
        total++; if (b2.busy !== 1'b0) begin bad++;
            $display("FAIL store_busy got=%0h exp=0", b2.busy); end
        total++; if (b2.d_rvalid !== 1'b0) begin bad++;
            $display("FAIL store_rvalid got=%0h exp=0", b2.d_rvalid); end
        total++; if (b2.if_gnt !== 1'b1 || b2.mem_addr !== 64'h48)
        begin bad++;
            $display("FAIL store_next_fetch got=%0h/%0h exp=1/48",
                     b2.if_gnt, b2.mem_addr); end
        @(posedge CLK); #1;
        b2.if_req = 0;
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic test_conflict();
        logic exp_d, exp_i, exp_drv;
        @(posedge CLK); #1;
        rst2 = 1;
        @(posedge CLK); #1;
        rst2 = 0;
        b2.if_req = 1; b2.if_addr = 64'h10;
        b2.d_req = 1; b2.d_we = 0; b2.d_addr = 64'h20;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
`ifdef ARB_ROUND_ROBIN_EN
            exp_d   = (k % 6 == 0);
            exp_i   = (k % 6 == 3);
            exp_drv = (k == 3) || (k == 9);
`else
            exp_d   = (k == 0);
            exp_i   = (k == 3);
            exp_drv = (k == 3);
`endif
            total++; if (b2.d_gnt !== exp_d) begin bad++;
                $display("FAIL conf_d_gnt c%0d got=%0h exp=%0h",
                         k, b2.d_gnt, exp_d); end
            total++; if (b2.if_gnt !== exp_i) begin bad++;
                $display("FAIL conf_if_gnt c%0d got=%0h exp=%0h",
                         k, b2.if_gnt, exp_i); end
            total++; if (b2.d_rvalid !== exp_drv) begin bad++;
                $display("FAIL conf_d_rvalid c%0d got=%0h exp=%0h",
                         k, b2.d_rvalid, exp_drv); end
            total++; if (b2.if_rvalid !== (k == 6)) begin bad++;
                $display("FAIL conf_if_rvalid c%0d got=%0h exp=%0h",
                         k, b2.if_rvalid, (k == 6)); end
            @(posedge CLK); #1;
`ifndef ARB_ROUND_ROBIN_EN
            if (k == 0) b2.d_req = 0;
            if (k == 3) b2.if_req = 0;
`endif
        end
        b2.if_req = 0; b2.d_req = 0;
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_rd;
        @(posedge CLK); #1;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 64'h0; b1.mem_rdata = 64'h0;
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            total++; if (b1.d_gnt !== (k % 2 == 0)) begin bad++;
                $display("FAIL b2b_gnt c%0d got=%0h exp=%0h",
                         k, b1.d_gnt, (k % 2 == 0)); end
            total++; if (b1.busy !== (k % 2 == 1)) begin bad++;
                $display("FAIL b2b_busy c%0d got=%0h exp=%0h",
                         k, b1.busy, (k % 2 == 1)); end
            total++;
            if (b1.d_rvalid !== (k >= 2 && k % 2 == 0)) begin bad++;
                $display("FAIL b2b_rvalid c%0d got=%0h exp=%0h",
                         k, b1.d_rvalid, (k >= 2 && k % 2 == 0)); end
            if (k >= 2 && k % 2 == 0) begin
                exp_rd = 64'h1000 + 64'(k - 1);
                total++; if (b1.d_rdata !== exp_rd) begin bad++;
                    $display("FAIL b2b_rdata c%0d got=%0h exp=%0h",
                             k, b1.d_rdata, exp_rd); end
            end
            if (k % 2 == 0) begin
                total++; if (b1.mem_addr !== 64'(8 * k)) begin bad++;
                    $display("FAIL b2b_addr c%0d got=%0h exp=%0h",
                             k, b1.mem_addr, 8 * k); end
            end
            @(posedge CLK); #1;
            b1.d_addr    = 64'(8 * (k + 1));
            b1.mem_rdata = (k % 2 == 0) ? 64'h1000 + 64'(k + 1)
                                        : 64'hDEAD;
        end
        b1.d_req = 0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_wait();
        @(posedge CLK); #1;
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 64'h30;
        b3.mem_rdata = 64'hBAD0;
        @(negedge CLK);
        total++; if (b3.d_gnt !== 1'b1) begin bad++;
            $display("FAIL rw_first_gnt got=%0h exp=1", b3.d_gnt); end
        @(posedge CLK); #1;
        b3.d_req = 0; rst3 = 1;
        @(negedge CLK);
        total++; if (b3.busy !== 1'b1) begin bad++;
            $display("FAIL rw_busy_c1 got=%0h exp=1", b3.busy); end
        @(posedge CLK); #1;
        rst3 = 0; b3.d_req = 1; b3.d_addr = 64'h38;
        @(negedge CLK);
        total++; if (b3.busy !== 1'b0) begin bad++;
            $display("FAIL rw_busy_after got=%0h exp=0", b3.busy); end
        total++; if (b3.d_gnt !== 1'b1 || b3.mem_addr !== 64'h38)
        begin bad++;
            $display("FAIL rw_regrant got=%0h/%0h exp=1/38",
                     b3.d_gnt, b3.mem_addr); end
        total++; if (b3.d_rdata !== 64'h0) begin bad++;
            $display("FAIL rw_rdata_rst got=%0h exp=0", b3.d_rdata); end
        for (int k = 3; k < 9; k++) begin
            @(posedge CLK); #1;
            b3.d_req = 0;
            b3.mem_rdata = (k == 5) ? 64'h5EED : 64'hBAD0 + 64'(k);
            @(negedge CLK);
            total++; if (b3.d_rvalid !== (k == 6)) begin bad++;
                $display("FAIL rw_rvalid c%0d got=%0h exp=%0h",
                         k, b3.d_rvalid, (k == 6)); end
            if (k == 6) begin
                total++; if (b3.d_rdata !== 64'h5EED) begin bad++;
                    $display("FAIL rw_rdata got=%0h exp=5eed", b3.d_rdata);
                end
            end
        end
    endtask

    task automatic test_random();
        int          free_c, rv_c, pend_c;
        logic        rv_who, last, pend_v, i_gr, d_gr;
        logic        free, exp_i, exp_d, exp_irv, exp_drv;
        logic [63:0] rv_word, pend_a, w;
        logic [60:0] idx;
        @(posedge CLK); #1;
        zero_inputs();
        rst2 = 1;
        @(posedge CLK); #1;
        rst2 = 0;
        mem_arr.delete();
        ref_mem.delete();
        free_c = 0; rv_c = -1; pend_c = -10; pend_v = 0;
        rv_who = 0; rv_word = 0; pend_a = 0;
        last = 0; i_gr = 1; d_gr = 1;
        for (int c = 0; c < 400; c++) begin
            @(posedge CLK); #1;
            if (i_gr || !b2.if_req) begin
                b2.if_req  = 1'($urandom_range(0, 1));
                b2.if_addr = 64'($urandom_range(0, 31)) << 2;
            end else if ($urandom_range(0, 15) == 0) begin
                b2.if_req = 0;
            end
            if (d_gr || !b2.d_req) begin
                b2.d_req   = 1'($urandom_range(0, 1));
                b2.d_we    = ($urandom_range(0, 2) == 0);
                b2.d_addr  = 64'($urandom_range(0, 15)) << 3;
                b2.d_wdata = {$urandom, $urandom};
            end else if ($urandom_range(0, 15) == 0) begin
                b2.d_req = 0;
            end
            i_gr = 0; d_gr = 0;
            if (pend_v && c == pend_c + 2) begin
                idx = pend_a[63:3];
                b2.mem_rdata = mem_arr.exists(idx) ? mem_arr[idx]
                                                   : init_word(idx);
            end else begin
                b2.mem_rdata = {$urandom, $urandom};
            end
            @(negedge CLK);
            free = (c >= free_c);
            total++; if (b2.busy !== !free) begin bad++;
                $display("FAIL rnd_busy c%0d got=%0h exp=%0h",
                         c, b2.busy, !free); end
            exp_irv = (c == rv_c) && (rv_who == 0);
            exp_drv = (c == rv_c) && (rv_who == 1);
            total++; if (b2.if_rvalid !== exp_irv) begin bad++;
                $display("FAIL rnd_if_rvalid c%0d got=%0h exp=%0h",
                         c, b2.if_rvalid, exp_irv); end
            total++; if (b2.d_rvalid !== exp_drv) begin bad++;
                $display("FAIL rnd_d_rvalid c%0d got=%0h exp=%0h",
                         c, b2.d_rvalid, exp_drv); end
            if (exp_irv) begin
                total++; if (b2.if_rdata !== rv_word[31:0]) begin bad++;
                    $display("FAIL rnd_if_rdata c%0d got=%0h exp=%0h",
                             c, b2.if_rdata, rv_word[31:0]); end
            end
            if (exp_drv) begin
                total++; if (b2.d_rdata !== rv_word) begin bad++;
                    $display("FAIL rnd_d_rdata c%0d got=%0h exp=%0h",
                             c, b2.d_rdata, rv_word); end
            end
            exp_i = 0; exp_d = 0;
            if (free) begin
                if (b2.if_req && b2.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (last) exp_i = 1;
                    else      exp_d = 1;
`else
                    exp_d = 1;
`endif
                end else begin
                    exp_i = b2.if_req;
                    exp_d = b2.d_req;
                end
            end
            total++; if ({b2.if_gnt, b2.d_gnt} !== {exp_i, exp_d})
            begin bad++;
                $display("FAIL rnd_gnt c%0d got=%0h exp=%0h",
                         c, {b2.if_gnt, b2.d_gnt}, {exp_i, exp_d}); end
            if (exp_d) begin
                last = 1; d_gr = 1;
                total++;
                if (b2.mem_addr !== b2.d_addr || b2.mem_we !== b2.d_we ||
                    b2.mem_re !== !b2.d_we) begin bad++;
                    $display("FAIL rnd_d_port c%0d got=%0h/%0h%0h exp=%0h/%0h",
                             c, b2.mem_addr, b2.mem_we, b2.mem_re,
                             b2.d_addr, b2.d_we); end
                idx = b2.d_addr[63:3];
                if (b2.d_we) begin
                    total++; if (b2.mem_wdata !== b2.d_wdata) begin bad++;
                        $display("FAIL rnd_wdata c%0d got=%0h exp=%0h",
                                 c, b2.mem_wdata, b2.d_wdata); end
                    ref_mem[idx] = b2.d_wdata;
                end else begin
                    free_c = c + 3; rv_c = c + 3; rv_who = 1;
                    rv_word = ref_mem.exists(idx) ? ref_mem[idx]
                                                  : init_word(idx);
                end
            end else if (exp_i) begin
                last = 0; i_gr = 1;
                total++;
                if (b2.mem_addr !== b2.if_addr || b2.mem_re !== 1'b1 ||
                    b2.mem_we !== 1'b0) begin bad++;
                    $display("FAIL rnd_i_port c%0d got=%0h exp=%0h",
                             c, b2.mem_addr, b2.if_addr); end
                idx = b2.if_addr[63:3];
                w = ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
                rv_word = {32'h0, b2.if_addr[2] ? w[63:32] : w[31:0]};
                free_c = c + 3; rv_c = c + 3; rv_who = 0;
            end else begin
                total++; if ({b2.mem_re, b2.mem_we} !== 2'b00) begin bad++;
                    $display("FAIL rnd_idle_strobe c%0d got=%0h exp=0",
                             c, {b2.mem_re, b2.mem_we}); end
            end
            if (b2.mem_we === 1'b1) mem_arr[b2.mem_addr[63:3]] = b2.mem_wdata;
            if (b2.mem_re === 1'b1) begin
                pend_v = 1; pend_c = c; pend_a = b2.mem_addr;
            end
        end
        zero_inputs();
    endtask

    initial begin
        zero_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_conflict();
        test_back_to_back();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
